// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding, default widths and operand extension for the CSA accumulator
package csa_pkg;
    typedef enum logic [1:0] {IDLE, ACC, RESOLVE, HOLD} state_t;
    localparam int DEF_IN_W = 23;
    localparam int DEF_ACC_W = 26;
    localparam int EXT_W = 64;
    function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] v, input int w, input bit sgn);
        logic [EXT_W-1:0] m;
        m = (EXT_W'(1) << w) - EXT_W'(1);
        return (v & m) | ((sgn && |(v & (EXT_W'(1) << (w - 1)))) ? ~m : '0);
    endfunction
endpackage

// File: rtl/csa_3to2_w.sv
// csa_3to2_w: W-bit 3:2 carry-save compressor; carry already shifted into its weight position
module csa_3to2_w #(
    parameter int W = 26
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);
    assign s = a ^ b ^ c;
    assign cy = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: streaming multi-operand accumulator, carry-save folding then one final add
module csa_accum_seq
    import csa_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SIGNED = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_cnt_ovf
);
    state_t state;
    logic [ACC_W-1:0] sum_r, carry_r, res_r, x, s_n, c_n;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    assign x = ACC_W'(ext(EXT_W'(in_data), IN_W, SIGNED != 0));
    csa_3to2_w #(.W(ACC_W)) u_csa (.a(sum_r), .b(carry_r), .c(x), .s(s_n), .cy(c_n));
    assign in_ready = !rst && (state == IDLE || state == ACC);
    assign out_valid = state == HOLD;
    assign out_data = res_r;
    assign out_count = cnt;
    assign out_cnt_ovf = ovf;
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= IDLE;
            sum_r <= '0;
            carry_r <= '0;
            res_r <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sum_r <= x;
                    carry_r <= '0;
                    cnt <= CNT_W'(1);
                    ovf <= 1'b0;
                    state <= in_last ? RESOLVE : ACC;
                end
                ACC: if (in_valid) begin
                    sum_r <= s_n;
                    carry_r <= c_n;
                    cnt <= &cnt ? cnt : cnt + 1'b1;
                    ovf <= ovf | &cnt;
                    state <= in_last ? RESOLVE : ACC;
                end
                RESOLVE: begin
                    res_r <= sum_r + carry_r;
                    state <= HOLD;
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
